// File: rtl/benes_pkg.sv
// Shared definitions for the 4-port Benes configuration scheduler.
//   N        : fabric port count
//   IDX_W    : bits per port index
//   PERM_W   : packed permutation width (N destinations of IDX_W bits)
//   SW_BITS  : number of 2x2 switches in the fabric
//   S0_0..S2_1 : bit positions of each switch inside the packed setting word
//   state_e  : scheduler FSM states
//   dest_of(): extract destination of one input from a packed permutation
package benes_pkg;

    localparam int N       = 4;
    localparam int IDX_W   = 2;
    localparam int PERM_W  = N * IDX_W;
    localparam int SW_BITS = 6;

    localparam int S0_0 = 0;   // input switch, inputs 0/1
    localparam int S0_1 = 1;   // input switch, inputs 2/3
    localparam int M_0  = 2;   // upper middle switch
    localparam int M_1  = 3;   // lower middle switch
    localparam int S2_0 = 4;   // output switch, outputs 0/1
    localparam int S2_1 = 5;   // output switch, outputs 2/3

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ROUTE_A,
        ST_ROUTE_B,
        ST_LOAD
    } state_e;

    function automatic logic [IDX_W-1:0] dest_of(input logic [PERM_W-1:0] perm,
                                                 input logic [IDX_W-1:0]  idx);
        return perm[{idx, 1'b0} +: IDX_W];
    endfunction

endpackage

// File: rtl/benes_perm_check.sv
// Combinational permutation checker: asserts is_perm when all N packed
// destinations are pairwise distinct. Parameterised so it can be reused
// for larger fabrics.
//   perm    in  N*IDX_W  packed destinations, entry i at [i*IDX_W +: IDX_W]
//   is_perm out 1        1 = every destination appears exactly once
module benes_perm_check #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N*IDX_W-1:0] perm,
    output logic               is_perm
);

    always_comb begin
        is_perm = 1'b1;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (perm[i*IDX_W +: IDX_W] == perm[j*IDX_W +: IDX_W]) begin
                    is_perm = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/benes_cfg_sched.sv
// Configuration scheduler for the 4-port Benes fabric. Accepts a requested
// permutation, validates it, computes the six switch settings with the
// looping algorithm, stages them in a shadow register and commits them to
// the live fabric only on a frame-sync pulse.
//   clk         in   1  clock, rising edge
//   rst         in   1  synchronous active-high reset
//   perm_in     in   8  destination of input i at [2i+1:2i]
//   perm_valid  in   1  perm_in valid
//   perm_ready  out  1  request can be accepted this cycle
//   swap_sync   in   1  frame boundary; commit point for a pending config
//   sw_state    out  6  live switch settings (1 = cross)
//   cfg_valid   out  1  sw_state loaded from an accepted permutation
//   pend        out  1  shadow holds a config awaiting swap_sync
//   cfg_update  out  1  pulse: sw_state changed this cycle
//   perm_err    out  1  pulse: last accepted request was not a permutation
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | waiting for a request (ready only when nothing pending)
// ST_CHECK   | verify the four destinations are distinct
// ST_ROUTE_A | fix S0_0, the output switch reached by input 0, and S0_1
// ST_ROUTE_B | fix the other output switch and both middle switches
// ST_LOAD    | copy the computed settings into the shadow, raise pend
module benes_cfg_sched
    import benes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [PERM_W-1:0]  perm_in,
    input  logic               perm_valid,
    output logic               perm_ready,
    input  logic               swap_sync,
    output logic [SW_BITS-1:0] sw_state,
    output logic               cfg_valid,
    output logic               pend,
    output logic               cfg_update,
    output logic               perm_err
);

    state_e               state_q, state_d;
    logic [PERM_W-1:0]    perm_q, perm_d;
    logic [SW_BITS-1:0]   route_q, route_d;
    logic [SW_BITS-1:0]   shadow_q, shadow_d;
    logic [SW_BITS-1:0]   sw_state_q, sw_state_d;
    logic                 cfg_valid_q, cfg_valid_d;
    logic                 pend_q, pend_d;
    logic                 cfg_update_q, cfg_update_d;
    logic                 perm_err_q, perm_err_d;

    logic                 is_perm;
    logic                 accept;
    logic                 commit;
    logic [IDX_W-1:0]     d0, d1, d2, d3, du, partner;

    benes_perm_check #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_perm_check (
        .perm    (perm_q),
        .is_perm (is_perm)
    );

    assign d0 = dest_of(perm_q, 2'd0);
    assign d1 = dest_of(perm_q, 2'd1);
    assign d2 = dest_of(perm_q, 2'd2);
    assign d3 = dest_of(perm_q, 2'd3);

    // Output paired with d0 on the same output switch; it must arrive via
    // the lower subnet because input 0 always takes the upper one.
    assign partner = d0 ^ 2'd1;

    // Switch-1 input that ends up on the upper subnet.
    assign du = route_q[S0_1] ? d3 : d2;

    assign perm_ready = (state_q == ST_IDLE) && !pend_q;
    assign accept     = perm_valid && perm_ready;
    assign commit     = swap_sync && pend_q;

    always_comb begin
        state_d      = state_q;
        perm_d       = perm_q;
        route_d      = route_q;
        shadow_d     = shadow_q;
        sw_state_d   = sw_state_q;
        cfg_valid_d  = cfg_valid_q;
        pend_d       = pend_q;
        cfg_update_d = 1'b0;
        perm_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    perm_d  = perm_in;
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (!is_perm) begin
                    perm_err_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    route_d = '0;
                    state_d = ST_ROUTE_A;
                end
            end

            ST_ROUTE_A: begin
                route_d[S0_0] = 1'b0;
                if (d0[1]) begin
                    route_d[S2_1] = d0[0];
                end else begin
                    route_d[S2_0] = d0[0];
                end
                // Partner on input 1 or 3 is already on the lower subnet with
                // S0_1 straight; only input 2 needs the cross.
                route_d[S0_1] = (d2 == partner);
                state_d       = ST_ROUTE_B;
            end

            ST_ROUTE_B: begin
                // du always lands on the output switch not set in ROUTE_A.
                if (du[1]) begin
                    route_d[S2_1] = du[0];
                end else begin
                    route_d[S2_0] = du[0];
                end
                route_d[M_0] = d0[1];
                route_d[M_1] = d1[1];
                state_d      = ST_LOAD;
            end

            ST_LOAD: begin
                shadow_d = route_q;
                pend_d   = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Commit can occur in any state; pend is never set in the same cycle
        // because LOAD is unreachable while a config is pending.
        if (commit) begin
            sw_state_d   = shadow_q;
            pend_d       = 1'b0;
            cfg_valid_d  = 1'b1;
            cfg_update_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            perm_q       <= '0;
            route_q      <= '0;
            shadow_q     <= '0;
            sw_state_q   <= '0;
            cfg_valid_q  <= 1'b0;
            pend_q       <= 1'b0;
            cfg_update_q <= 1'b0;
            perm_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            perm_q       <= perm_d;
            route_q      <= route_d;
            shadow_q     <= shadow_d;
            sw_state_q   <= sw_state_d;
            cfg_valid_q  <= cfg_valid_d;
            pend_q       <= pend_d;
            cfg_update_q <= cfg_update_d;
            perm_err_q   <= perm_err_d;
        end
    end

    assign sw_state   = sw_state_q;
    assign cfg_valid  = cfg_valid_q;
    assign pend       = pend_q;
    assign cfg_update = cfg_update_q;
    assign perm_err   = perm_err_q;

endmodule

// File: tb/tb_benes_cfg_sched.sv
module tb_benes_cfg_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] perm_in;
    logic       perm_valid;
    logic       perm_ready;
    logic       swap_sync;
    logic [5:0] sw_state;
    logic       cfg_valid;
    logic       pend;
    logic       cfg_update;
    logic       perm_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [5:0] live_exp;
    bit         live_known;

    typedef struct {
        logic [7:0] perm;
        bit         err;
        logic [5:0] sw;
        int         sync_cyc;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    benes_cfg_sched dut (
        .clk        (clk),
        .rst        (rst),
        .perm_in    (perm_in),
        .perm_valid (perm_valid),
        .perm_ready (perm_ready),
        .swap_sync  (swap_sync),
        .sw_state   (sw_state),
        .cfg_valid  (cfg_valid),
        .pend       (pend),
        .cfg_update (cfg_update),
        .perm_err   (perm_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Independent fabric model: trace input i through the three stages.
    function automatic logic [1:0] fabric_out(input logic [5:0] sw, input logic [1:0] i);
        logic k, sub, outsw, pos;
        k     = i[1];
        sub   = i[0] ^ sw[k];
        outsw = k ^ (sub ? sw[3] : sw[2]);
        pos   = sub ^ (outsw ? sw[5] : sw[4]);
        return {outsw, pos};
    endfunction

    // Cycle numbering: cycle n ends with edge n; the request is accepted at
    // edge 0, so the negedge after it lies in cycle 1.
    task automatic run_req(input logic [7:0] p, input bit exp_err, input int sync_cyc);
        @(negedge clk);
        chk("ready_before_accept", perm_ready, 1);
        perm_in    = p;
        perm_valid = 1'b1;
        @(negedge clk);                      // cycle 1
        perm_valid = 1'b0;
        chk("busy_in_check", perm_ready, 0);
        @(negedge clk);                      // cycle 2
        if (exp_err) begin
            chk("perm_err_pulse", perm_err, 1);
            chk("pend_after_err", pend, 0);
            @(negedge clk);                  // cycle 3
            chk("perm_err_single", perm_err, 0);
            chk("ready_after_err", perm_ready, 1);
            chk("pend_still_low", pend, 0);
            if (live_known) chk("sw_hold_err", sw_state, live_exp);
        end else begin
            chk("no_perm_err", perm_err, 0);
            @(negedge clk);                  // cycle 3
            @(negedge clk);                  // cycle 4 (LOAD)
            chk("pend_in_load", pend, 0);
            if (live_known) chk("sw_hold_compute", sw_state, live_exp);
            for (int c = 5; c <= sync_cyc; c++) begin
                @(negedge clk);
                chk($sformatf("pend_c%0d", c), pend, 1);
                chk($sformatf("ready_c%0d", c), perm_ready, 0);
            end
            if (live_known) chk("sw_hold_pend", sw_state, live_exp);
            swap_sync = 1'b1;
            @(negedge clk);
            swap_sync = 1'b0;
            chk("cfg_update_pulse", cfg_update, 1);
            chk("pend_cleared", pend, 0);
            chk("cfg_valid_set", cfg_valid, 1);
            chk("ready_after_commit", perm_ready, 1);
            @(negedge clk);
            chk("cfg_update_single", cfg_update, 0);
        end
    endtask

    initial begin
        bit saw;
        logic [7:0] p;
        logic [1:0] dv [4];

        vecs[0] = '{perm: 8'hE4, err: 1'b0, sw: 6'h00, sync_cyc: 6};
        vecs[1] = '{perm: 8'h1B, err: 1'b0, sw: 6'h3C, sync_cyc: 5};
        vecs[2] = '{perm: 8'hD8, err: 1'b0, sw: 6'h2A, sync_cyc: 7};
        vecs[3] = '{perm: 8'hE0, err: 1'b1, sw: 6'h2A, sync_cyc: 5};

        rst        = 1'b1;
        perm_in    = '0;
        perm_valid = 1'b0;
        swap_sync  = 1'b0;
        live_exp   = 6'h00;
        live_known = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sw_state", sw_state, 0);
        chk("rst_cfg_valid", cfg_valid, 0);
        chk("rst_pend", pend, 0);
        chk("rst_cfg_update", cfg_update, 0);
        chk("rst_perm_err", perm_err, 0);
        chk("rst_perm_ready", perm_ready, 1);
        rst = 1'b0;

        // swap_sync with nothing pending has no effect
        @(negedge clk);
        swap_sync = 1'b1;
        @(negedge clk);
        swap_sync = 1'b0;
        chk("idle_sync_no_update", cfg_update, 0);
        chk("idle_sync_no_valid", cfg_valid, 0);

        for (int v = 0; v < 4; v++) begin
            run_req(vecs[v].perm, vecs[v].err, vecs[v].sync_cyc);
            chk($sformatf("vec%0d_sw_state", v), sw_state, vecs[v].sw);
            live_exp = vecs[v].sw;
        end

        // Back-pressure and LOAD-cycle swap_sync miss; live state is 2A.
        @(negedge clk);
        perm_in    = 8'h1B;
        perm_valid = 1'b1;
        @(negedge clk);                      // cycle 1
        perm_valid = 1'b0;
        @(negedge clk);                      // cycle 2
        @(negedge clk);                      // cycle 3
        @(negedge clk);                      // cycle 4 (LOAD)
        swap_sync = 1'b1;
        @(negedge clk);                      // cycle 5
        chk("load_sync_missed_pend", pend, 1);
        chk("load_sync_missed_sw", sw_state, 6'h2A);
        chk("load_sync_no_update", cfg_update, 0);
        perm_in    = 8'hE4;
        perm_valid = 1'b1;                   // refused: pend is high
        @(negedge clk);                      // cycle 6
        swap_sync  = 1'b0;
        perm_valid = 1'b0;
        chk("c5_commit_sw", sw_state, 6'h3C);
        chk("c5_commit_update", cfg_update, 1);
        chk("c5_commit_pend", pend, 0);
        saw = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (pend || !perm_ready) saw = 1'b1;
        end
        chk("backpressure_dropped", saw, 0);
        live_exp = 6'h3C;

        // Reset in ROUTE_A aborts and discards the request.
        @(negedge clk);
        perm_in    = 8'hD8;
        perm_valid = 1'b1;
        @(negedge clk);                      // cycle 1
        perm_valid = 1'b0;
        @(negedge clk);                      // cycle 2 (ROUTE_A)
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_sw_state", sw_state, 0);
        chk("abort_cfg_valid", cfg_valid, 0);
        chk("abort_pend", pend, 0);
        chk("abort_cfg_update", cfg_update, 0);
        chk("abort_perm_err", perm_err, 0);
        chk("abort_perm_ready", perm_ready, 1);
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (pend || cfg_update) saw = 1'b1;
        end
        chk("abort_discarded", saw, 0);
        live_exp = 6'h00;
        run_req(8'hD8, 1'b0, 5);
        chk("after_abort_sw", sw_state, 6'h2A);

        // All 24 permutations, checked by tracing every input through the fabric.
        live_known = 1'b0;
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 4; c++)
                    for (int d = 0; d < 4; d++) begin
                        if (a != b && a != c && a != d && b != c && b != d && c != d) begin
                            dv[0] = 2'(a);
                            dv[1] = 2'(b);
                            dv[2] = 2'(c);
                            dv[3] = 2'(d);
                            p = {dv[3], dv[2], dv[1], dv[0]};
                            run_req(p, 1'b0, 5);
                            for (int i = 0; i < 4; i++)
                                chk($sformatf("route_%02h_in%0d", p, i),
                                    fabric_out(sw_state, 2'(i)), dv[i]);
                        end
                    end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/benes_cfg_sched.md
# benes_cfg_sched

Configuration scheduler for the 4-port Benes switch fabric. It accepts a requested permutation over a valid/ready handshake and checks that it is a true permutation. It computes the six 2x2 switch settings with a multi-cycle looping-algorithm FSM and stages them in a shadow register. It commits them to the live fabric only on an external frame-sync pulse, so the datapath never sees a half-updated configuration.

## Interface
- No parameters; fabric size fixed at N=4 (6 switches, 2-bit port indices).
- clk  in  1  sole clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- perm_in  in  8  requested permutation: bits [2i+1:2i] = destination output of input i
- perm_valid  in  1  perm_in valid
- perm_ready  out  1  block can accept a permutation this cycle
- swap_sync  in  1  frame-boundary pulse; commit point for a pending config
- sw_state  out  6  live switch settings, 1=cross: [0]=S0_0 (inputs 0/1), [1]=S0_1 (inputs 2/3), [2]=M_0 (upper middle), [3]=M_1 (lower middle), [4]=S2_0 (outputs 0/1), [5]=S2_1 (outputs 2/3)
- cfg_valid  out  1  sw_state was loaded from an accepted permutation since reset
- pend  out  1  shadow holds a computed config awaiting swap_sync
- cfg_update  out  1  one-cycle pulse: sw_state changed this cycle
- perm_err  out  1  one-cycle pulse: last accepted perm_in was not a permutation

## Operation
- Switch convention, straight: input switch k sends input 2k to upper subnet and 2k+1 to lower. Middle switch port j connects to outer switch j. Output switch j sends upper to output 2j and lower to 2j+1. Cross swaps. All-zero = identity.
- Handshake: perm_ready = (state==IDLE) && !pend. Transfer when perm_valid && perm_ready; perm_in captured into perm_q. perm_valid without perm_ready is ignored (no queueing).
- FSM: IDLE -> CHECK -> ROUTE_A -> ROUTE_B -> LOAD -> IDLE.
- CHECK: the four destinations of perm_q must be pairwise distinct. On failure: perm_err pulses, go to IDLE, shadow/pend untouched.
- ROUTE_A: S0_0=0 always. S2_(d0[1]) = d0[0]. Find input i with d_i = d0^1.
  - If i==1: S0_1=0 (loop closed).
  - If i==2: S0_1=1.
  - If i==3: S0_1=0.
- ROUTE_B: u = S0_1 ? 3 : 2 (switch-1 input routed upper). S2_(d_u[1]) = d_u[0], always the output switch not set in ROUTE_A. M_0 = d0[1]; M_1 = d1[1].
- LOAD: shadow <= computed 6 bits; pend <= 1.
- Commit: in any state, if swap_sync && pend at an edge, then sw_state <= shadow, pend <= 0, cfg_valid <= 1, and cfg_update = 1 in the following cycle. swap_sync with pend=0 has no effect.

## Timing
- Reset values: sw_state=0, cfg_valid=0, pend=0, cfg_update=0, perm_err=0, state=IDLE, perm_ready=1.
- Acceptance edge = cycle 0. CHECK=1, ROUTE_A=2, ROUTE_B=3, LOAD=4; pend high from cycle 5. perm_err high in cycle 2 on failure.
- swap_sync in the LOAD cycle misses (pend still 0); the earliest commit is swap_sync sampled in cycle 5.
- perm_ready returns to 1 the cycle after commit, or the cycle after perm_err.
- rst mid-computation aborts the FSM and discards perm_q and shadow; outputs return to reset values next cycle.
- sw_state changes only on a commit edge, never during computation.

## Structure
- Shared package benes_pkg: N=4, SW_BITS=6, switch bit-index constants (S0_0..S2_1), FSM state enum.
- One sub-module, benes_perm_check: combinational distinct-destination checker, reusable for larger N. The route logic stays inline.

## Test plan
- Identity: perm_in=8'hE4 (d=0,1,2,3), swap_sync at cycle 6 -> sw_state=6'h00, cfg_valid=1, cfg_update single pulse.
- Reversal d=3,2,1,0 (perm_in=8'h1B) -> shadow 6'h3C. Commit on swap_sync; pend drops and perm_ready rises the next cycle.
- Cross path d=0,2,1,3 (perm_in=8'hD8) -> sw_state=6'h2A. Bench model routes all 4 inputs through the fabric for all 24 permutations, with no perm_err.
- Invalid d=0,0,2,3 (perm_in=8'hE0) -> perm_err pulse in cycle 2, pend stays 0, sw_state unchanged.
- Back-pressure: second perm_valid while pend=1 -> not accepted. swap_sync in LOAD cycle -> no commit; swap_sync in cycle 5 -> commit.
- rst asserted during ROUTE_A -> all outputs at reset values next cycle; a subsequent request completes normally.
